// File: rtl/ray_march.sv
// Fixed-step voxel ray marcher: walks a ray through a 3-D occupancy map one
// direction vector per step and reports the first occupied cell, or a miss.
module ray_march #(
    parameter int MAP_XW    = 5,
    parameter int MAP_YW    = 5,
    parameter int MAP_ZW    = 3,
    parameter int FRAC      = 4,
    parameter int MAX_STEPS = 63
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ray_valid,
    output logic                            ray_ready,
    input  logic [30:0]                     ray_dir,
    input  logic [12:0]                     ray_loc,
    input  logic [MAP_XW+FRAC-1:0]          cam_x,
    input  logic [MAP_YW+FRAC-1:0]          cam_y,
    input  logic [MAP_ZW+FRAC-1:0]          cam_z,
    output logic [MAP_XW+MAP_YW+MAP_ZW-1:0] map_addr,
    input  logic [3:0]                      map_data,
    output logic                            hit_valid,
    input  logic                            hit_ready,
    output logic                            hit_flag,
    output logic [3:0]                      hit_cell,
    output logic [7:0]                      hit_dist,
    output logic [12:0]                     hit_loc
);

    typedef enum logic [1:0] {IDLE, FETCH, CHECK, OUT} state_t;

    state_t             state_q, state_d;
    logic signed [15:0] px_q, px_d, py_q, py_d, pz_q, pz_d;
    logic signed [15:0] dx_q, dx_d, dy_q, dy_d, dz_q, dz_d;
    logic [7:0]         step_q, step_d;
    logic [12:0]        loc_q, loc_d;
    logic               hit_valid_q, hit_valid_d;
    logic               hit_flag_q, hit_flag_d;
    logic [3:0]         hit_cell_q, hit_cell_d;
    logic [7:0]         hit_dist_q, hit_dist_d;
    logic [12:0]        hit_loc_q, hit_loc_d;
    logic               out_of_bounds;

    // Negative positions show up as a set sign bit; the upper bound is 2^(W+FRAC).
    assign out_of_bounds = px_q[15] || (px_q[14:0] >= 15'(2 ** (MAP_XW + FRAC)))
                        || py_q[15] || (py_q[14:0] >= 15'(2 ** (MAP_YW + FRAC)))
                        || pz_q[15] || (pz_q[14:0] >= 15'(2 ** (MAP_ZW + FRAC)));

    assign map_addr  = {pz_q[FRAC +: MAP_ZW], py_q[FRAC +: MAP_YW], px_q[FRAC +: MAP_XW]};
    assign ray_ready = (state_q == IDLE);
    assign hit_valid = hit_valid_q;
    assign hit_flag  = hit_flag_q;
    assign hit_cell  = hit_cell_q;
    assign hit_dist  = hit_dist_q;
    assign hit_loc   = hit_loc_q;

    always_comb begin
        state_d     = state_q;
        px_d        = px_q;
        py_d        = py_q;
        pz_d        = pz_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        dz_d        = dz_q;
        step_d      = step_q;
        loc_d       = loc_q;
        hit_valid_d = hit_valid_q;
        hit_flag_d  = hit_flag_q;
        hit_cell_d  = hit_cell_q;
        hit_dist_d  = hit_dist_q;
        hit_loc_d   = hit_loc_q;
        case (state_q)
            IDLE: begin
                if (ray_valid) begin
                    px_d    = {{(16 - MAP_XW - FRAC){1'b0}}, cam_x};
                    py_d    = {{(16 - MAP_YW - FRAC){1'b0}}, cam_y};
                    pz_d    = {{(16 - MAP_ZW - FRAC){1'b0}}, cam_z};
                    dx_d    = {{5{ray_dir[30]}}, ray_dir[30:20]};
                    dy_d    = {{5{ray_dir[19]}}, ray_dir[19:9]};
                    dz_d    = {{7{ray_dir[8]}}, ray_dir[8:0]};
                    step_d  = 8'd0;
                    loc_d   = ray_loc;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (out_of_bounds) begin
                    hit_valid_d = 1'b1;
                    hit_flag_d  = 1'b0;
                    hit_cell_d  = 4'd0;
                    hit_dist_d  = step_q;
                    hit_loc_d   = loc_q;
                    state_d     = OUT;
                end else begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (map_data != 4'd0) begin
                    hit_valid_d = 1'b1;
                    hit_flag_d  = 1'b1;
                    hit_cell_d  = map_data;
                    hit_dist_d  = step_q;
                    hit_loc_d   = loc_q;
                    state_d     = OUT;
                end else if (step_q == 8'(MAX_STEPS)) begin
                    hit_valid_d = 1'b1;
                    hit_flag_d  = 1'b0;
                    hit_cell_d  = 4'd0;
                    hit_dist_d  = 8'(MAX_STEPS);
                    hit_loc_d   = loc_q;
                    state_d     = OUT;
                end else begin
                    px_d    = px_q + dx_q;
                    py_d    = py_q + dy_q;
                    pz_d    = pz_q + dz_q;
                    step_d  = step_q + 8'd1;
                    state_d = FETCH;
                end
            end
            OUT: begin
                if (hit_ready) begin
                    hit_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            px_q        <= '0;
            py_q        <= '0;
            pz_q        <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            dz_q        <= '0;
            step_q      <= '0;
            loc_q       <= '0;
            hit_valid_q <= 1'b0;
            hit_flag_q  <= 1'b0;
            hit_cell_q  <= '0;
            hit_dist_q  <= '0;
            hit_loc_q   <= '0;
        end else begin
            state_q     <= state_d;
            px_q        <= px_d;
            py_q        <= py_d;
            pz_q        <= pz_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            dz_q        <= dz_d;
            step_q      <= step_d;
            loc_q       <= loc_d;
            hit_valid_q <= hit_valid_d;
            hit_flag_q  <= hit_flag_d;
            hit_cell_q  <= hit_cell_d;
            hit_dist_q  <= hit_dist_d;
            hit_loc_q   <= hit_loc_d;
        end
    end

endmodule
